dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the single-port data memory between the CPU's M stage and a second bus master (DMA/debug port). The CPU has priority. A starvation counter forces one DMA grant after a bounded wait, and the CPU is stalled for that cycle. The block sits between the M-stage memory signals and the synchronous DMEM array and returns read data tagged to the requester that owned the access.

## Interface
- DBITS, 32, data and address width
- DMEMADDRBITS, 16, byte-address bits decoded as DMEM
- DMEMWORDBITS, 2, byte-offset bits dropped to form the word index
- STARVELIMIT, 4, consecutive denied DMA cycles before a forced DMA grant (1..15)

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- RESET_N  in  1  reset, asynchronous and active-low
- cpu_req  in  1  CPU M-stage access valid (wrmem or load)
- cpu_we  in  1  CPU write
- cpu_addr  in  DBITS  CPU byte address
- cpu_wdata  in  DBITS  CPU store data
- cpu_stall  out  1  CPU DMEM access not taken this cycle; CPU must hold and retry
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DBITS  CPU read data
- dma_req  in  1  DMA access request; held until granted
- dma_we  in  1  DMA write
- dma_addr  in  DBITS  DMA byte address
- dma_wdata  in  DBITS  DMA write data
- dma_gnt  out  1  DMA request accepted this cycle
- dma_rvalid  out  1  DMA read data valid
- dma_rdata  out  DBITS  DMA read data
- mem_we  out  1  DMEM write enable
- mem_addr  out  DMEMADDRBITS-DMEMWORDBITS  DMEM word index
- mem_wdata  out  DBITS  DMEM write data
- mem_rdata  in  DBITS  DMEM read data, valid one cycle after mem_addr

## Operation
- DMEM hit: addr[DBITS-1:DMEMADDRBITS]==0. Only hits compete for the array.
- CPU access that is not a hit: ignored by the arbiter. No stall, no rvalid (I/O is decoded elsewhere).
- DMA access that is not a hit: granted immediately with no memory access. dma_rvalid is returned next cycle with dma_rdata=32'hDEADDEAD, even for writes.
- Starvation counter starve_cnt (4 bits):
  - increments each cycle dma_req is high, the request is a hit, and it is not granted
  - clears on dma_gnt
  - saturates at STARVELIMIT
- forced = (starve_cnt==STARVELIMIT).
- Arbitration per cycle, with hit requests only:
  - CPU only: CPU wins.
  - DMA only: DMA wins.
  - Both, !forced: CPU wins; the DMA waits.
  - Both, forced: DMA wins; cpu_stall=1.
- Winner drives mem_we/mem_addr/mem_wdata. With no winner, mem_we=0 and mem_addr holds its previous value.
- Owner register (NONE/CPU/DMA/DMAX): records the winner of a read; DMAX marks a non-hit DMA access. It drives the next-cycle rvalid and selects rdata. Writes load NONE.
- Reads of cpu_rdata/dma_rdata when the matching rvalid=0 are don't-care; they drive 0.

## Timing
- dma_gnt, cpu_stall and mem_* are combinational from the current-cycle requests and registered starve_cnt.
- Read latency is 1 cycle: rvalid is high for exactly the cycle after the grant.
- Write commits at the grant edge.
- Writes and reads in consecutive cycles to the same word see the new data.
- DMA master must hold dma_addr/we/wdata stable while dma_req=1 and dma_gnt=0.
- Stalled CPU request re-arbitrates next cycle; starve_cnt is 0 then, so the CPU wins.
- Forced grants occur at most once every STARVELIMIT+1 cycles under continuous contention.
- Reset (RESET_N low, any time):
  - starve_cnt=0, owner=NONE
  - cpu_rvalid=dma_rvalid=0, cpu_stall=0, dma_gnt=0, mem_we=0
  - a pending read return is dropped
- Requests are ignored while RESET_N is low.

## Structure
- Shared package `dmem_arb_pkg` holds:
  - the owner enum (NONE, CPU, DMA, DMAX)
  - the DEADDEAD constant
  - the DMEM hit-decode function
- One sub-module `starve_ctr`: saturating counter with inc/clr inputs and a `forced` output.
- Arbitration and return muxing stay in the top module.

## Test plan
- CPU read 0x0000_0040 alone -> mem_addr=0x010, mem_we=0; next cycle cpu_rvalid=1, cpu_rdata=mem_rdata; cpu_stall=0 throughout.
- DMA write 0x0000_0100 = 0x1234_5678 alone -> dma_gnt same cycle. A following DMA read of 0x0000_0100 returns dma_rdata=0x1234_5678.
- Continuous CPU and DMA hit requests, STARVELIMIT=4:
  - DMA denied 4 cycles, granted on the 5th with cpu_stall=1.
  - Next cycle the CPU wins and starve_cnt=0.
  - Pattern repeats every 5 cycles.
- DMA read 0xFFFF_F020 (non-hit) concurrent with a CPU hit -> both granted, no stall. Next cycle dma_rvalid=1 with 0xDEADDEAD and cpu_rvalid=1.
- CPU store to 0xFFFF_F000 with a DMA hit pending -> DMA granted, mem_we from DMA only, no cpu_stall.
- RESET_N pulsed low the cycle after a CPU read grant -> cpu_rvalid never asserts, starve_cnt=0, all outputs 0 until release.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types, constants and address decode for the DMEM arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2,
    OWN_DMAX = 2'd3
  } owner_e;

  localparam logic [31:0] DEADDEAD = 32'hDEAD_DEAD;

  // An address hits DMEM when every bit above the DMEM window is zero.
  function automatic logic dmem_hit(input logic [63:0] addr, input int unsigned abits);
    return ((addr >> abits) == 64'd0);
  endfunction

endpackage

// File: rtl/dmem_arbiter_starve_ctr.sv
// Saturating count of consecutive denied DMA cycles; flags when a DMA grant must be forced.
module starve_ctr #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic forced_o
);

  localparam logic [3:0] LIM = 4'(LIMIT);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Next count: clear wins over increment, increment stops at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 4'd0;
    end else if (inc_i && (cnt_q != LIM)) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign forced_o = (cnt_q == LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port DMEM between the CPU M stage (priority) and a DMA master,
// with a starvation-forced DMA grant and owner-tagged read returns.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DBITS        = 32,
  parameter int unsigned DMEMADDRBITS = 16,
  parameter int unsigned DMEMWORDBITS = 2,
  parameter int unsigned STARVELIMIT  = 4
) (
  input  logic                                 clk,
  input  logic                                 RESET_N,
  input  logic                                 cpu_req,
  input  logic                                 cpu_we,
  input  logic [DBITS-1:0]                     cpu_addr,
  input  logic [DBITS-1:0]                     cpu_wdata,
  output logic                                 cpu_stall,
  output logic                                 cpu_rvalid,
  output logic [DBITS-1:0]                     cpu_rdata,
  input  logic                                 dma_req,
  input  logic                                 dma_we,
  input  logic [DBITS-1:0]                     dma_addr,
  input  logic [DBITS-1:0]                     dma_wdata,
  output logic                                 dma_gnt,
  output logic                                 dma_rvalid,
  output logic [DBITS-1:0]                     dma_rdata,
  output logic                                 mem_we,
  output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] mem_addr,
  output logic [DBITS-1:0]                     mem_wdata,
  input  logic [DBITS-1:0]                     mem_rdata
);

  localparam int unsigned WBITS = DMEMADDRBITS - DMEMWORDBITS;

  logic             cpu_hit_s;
  logic             dma_hit_s;
  logic             dma_miss_s;
  logic             forced_s;
  logic             cpu_win_s;
  logic             dma_win_s;
  logic             starve_inc_s;
  logic [WBITS-1:0] addr_q;
  logic [WBITS-1:0] addr_d;
  owner_e           owner_q;
  owner_e           owner_d;
  logic             cpu_xrd_q;
  logic             cpu_xrd_d;

  // Requests are masked while reset is held so nothing is granted during reset.
  always_comb begin
    cpu_hit_s    = RESET_N & cpu_req & dmem_hit(64'(cpu_addr), DMEMADDRBITS);
    dma_hit_s    = RESET_N & dma_req & dmem_hit(64'(dma_addr), DMEMADDRBITS);
    dma_miss_s   = RESET_N & dma_req & ~dmem_hit(64'(dma_addr), DMEMADDRBITS);
    dma_win_s    = dma_hit_s & (~cpu_hit_s | forced_s);
    cpu_win_s    = cpu_hit_s & ~dma_win_s;
    dma_gnt      = dma_win_s | dma_miss_s;
    cpu_stall    = cpu_hit_s & dma_win_s;
    starve_inc_s = dma_hit_s & ~dma_win_s;
  end

  starve_ctr #(
    .LIMIT(STARVELIMIT)
  ) u_starve_ctr (
    .clk     (clk),
    .rst_n   (RESET_N),
    .inc_i   (starve_inc_s),
    .clr_i   (dma_gnt),
    .forced_o(forced_s)
  );

  // Winner drives the array port; an idle cycle keeps the last word index.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = {DBITS{1'b0}};
    if (dma_win_s) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr[DMEMADDRBITS-1:DMEMWORDBITS];
      mem_wdata = dma_wdata;
    end else if (cpu_win_s) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr[DMEMADDRBITS-1:DMEMWORDBITS];
      mem_wdata = cpu_wdata;
    end else begin
      mem_we    = 1'b0;
      mem_addr  = addr_q;
      mem_wdata = {DBITS{1'b0}};
    end
    addr_d = mem_addr;
  end

  // A DMA miss can share its cycle with a CPU array read, hence the side flag.
  always_comb begin
    owner_d   = OWN_NONE;
    cpu_xrd_d = 1'b0;
    if (dma_miss_s) begin
      owner_d   = OWN_DMAX;
      cpu_xrd_d = cpu_win_s & ~cpu_we;
    end else if (dma_win_s && !dma_we) begin
      owner_d = OWN_DMA;
    end else if (cpu_win_s && !cpu_we) begin
      owner_d = OWN_CPU;
    end else begin
      owner_d = OWN_NONE;
    end
  end

  // Owner and held address registers.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      owner_q   <= OWN_NONE;
      cpu_xrd_q <= 1'b0;
      addr_q    <= {WBITS{1'b0}};
    end else begin
      owner_q   <= owner_d;
      cpu_xrd_q <= cpu_xrd_d;
      addr_q    <= addr_d;
    end
  end

  // Return path: route the array data to the requester that owned last cycle's read.
  always_comb begin
    cpu_rvalid = (owner_q == OWN_CPU) | cpu_xrd_q;
    dma_rvalid = 1'b0;
    dma_rdata  = {DBITS{1'b0}};
    if (cpu_rvalid) begin
      cpu_rdata = mem_rdata;
    end else begin
      cpu_rdata = {DBITS{1'b0}};
    end
    case (owner_q)
      OWN_DMA: begin
        dma_rvalid = 1'b1;
        dma_rdata  = mem_rdata;
      end
      OWN_DMAX: begin
        dma_rvalid = 1'b1;
        dma_rdata  = DBITS'(DEADDEAD);
      end
      default: begin
        dma_rvalid = 1'b0;
        dma_rdata  = {DBITS{1'b0}};
      end
    endcase
  end

endmodule
